arp_resolver: RTL and testbench
===============================

# arp_resolver

Next-hop MAC resolver between the UDP/IP transmit path and the MAC cache. It takes a destination IP, looks it up in the cache, and on a miss issues ARP requests to the ARP transmit stage. It then waits for a matching ARP reply and retries on timeout. It returns either the 48-bit MAC or a failure pulse to the IP transmit path.

## Interface
- TIMEOUT_CYCLES, 125_000_000: cycles to wait for an ARP reply per attempt (≥2).
- RETRY_MAX, 3: total ARP request attempts before failure (1..15).
- I_clk  in  1  single clock for all logic; cache read clock is the same clock.
- I_reset_n  in  1  reset, asynchronous assert, active-low.
- I_req  in  1  resolve request, single-cycle pulse; sampled only when O_busy=0.
- I_req_ip  in  32  destination IP, valid with I_req.
- O_busy  out  1  high from the cycle after an accepted I_req until the result pulse cycle, inclusive.
- O_cache_ren  out  1  cache read strobe, one-cycle pulse.
- O_cache_rip  out  32  cache lookup IP, held stable while O_busy.
- I_cache_mac  in  48  cache read data; 48'd0 means miss.
- I_cache_done  in  1  cache read valid, one cycle after O_cache_ren.
- O_arp_req  out  1  ARP request trigger to ARP transmit stage, one-cycle pulse.
- O_arp_req_ip  out  32  target IP for ARP request; equals O_cache_rip.
- I_arp_rx_valid  in  1  ARP reply received, one-cycle pulse.
- I_arp_rx_ip  in  32  sender IP of received reply.
- I_arp_rx_mac  in  48  sender MAC of received reply.
- O_mac_valid  out  1  resolution success, one-cycle pulse.
- O_mac  out  48  resolved MAC; holds its value until the next O_mac_valid.
- O_fail  out  1  resolution failed after RETRY_MAX attempts, one-cycle pulse.

## Operation
- States: IDLE, LOOKUP, WAIT_LOOKUP, ARP_SEND, ARP_WAIT, DONE, FAIL.
- IDLE:
  - I_req=1 latches I_req_ip into the target register.
  - If the IP is 32'hFFFF_FFFF, go to DONE with MAC 48'hFFFF_FFFF_FFFF and no cache access.
  - Otherwise go to LOOKUP.
- LOOKUP: assert O_cache_ren for one cycle, then go to WAIT_LOOKUP.
- WAIT_LOOKUP:
  - Wait for I_cache_done.
  - I_cache_mac≠0: capture it and go to DONE.
  - I_cache_mac=0: clear the retry counter and go to ARP_SEND.
- ARP_SEND:
  - Pulse O_arp_req for one cycle.
  - Increment the retry counter (4 bits).
  - Load the timer with TIMEOUT_CYCLES-1.
  - Go to ARP_WAIT.
- ARP_WAIT: the timer decrements each cycle.
  - I_arp_rx_valid with I_arp_rx_ip == target: capture I_arp_rx_mac and go to DONE.
  - Non-matching replies are ignored.
  - Timer reaches 0 with no matching reply:
    - retry counter < RETRY_MAX → ARP_SEND.
    - otherwise → FAIL.
- DONE: O_mac_valid=1 for one cycle, O_mac updated in the same cycle, then IDLE.
- FAIL: O_fail=1 for one cycle, O_mac unchanged, then IDLE.
- This block does not write the cache; the ARP receive stage writes it from the same reply.
- The timer is ceil(log2(TIMEOUT_CYCLES)) bits wide. The retry compare is unsigned.

## Timing
- Reset (I_reset_n=0, any time, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: O_busy, O_cache_ren, O_cache_rip, O_arp_req, O_arp_req_ip, O_mac_valid, O_mac, O_fail.
  - Timer and retry counter clear.
  - An in-flight request is discarded with no result pulse.
- All outputs are registered.
- With the request pulse at cycle t:
  - O_busy is high from t+1.
  - O_cache_ren is high at t+1.
  - I_cache_done is expected at t+2.
  - Cache hit: O_mac_valid at t+3.
  - Broadcast: O_mac_valid at t+1.
- Miss:
  - O_arp_req is high at t+3.
  - A matching reply at cycle r gives O_mac_valid at r+1.
  - Each attempt waits exactly TIMEOUT_CYCLES cycles after its O_arp_req cycle; the next O_arp_req is at that cycle + TIMEOUT_CYCLES + 1.
  - Failure: O_fail is pulsed one cycle after the final timer expiry.
- I_req while O_busy=1 is ignored. There is no queue, and the requester must retry.
- A new I_req is accepted in the cycle after the O_mac_valid/O_fail pulse.
- A matching reply in the same cycle the timer hits 0: the reply wins and the result is success.
- A reply arriving during WAIT_LOOKUP or ARP_SEND is ignored. The protocol retries it.
- I_cache_done is guaranteed one cycle after O_cache_ren. WAIT_LOOKUP has no timeout.

## Test plan
- Cache hit: cache returns 48'h0011_2233_4455 for 192.168.1.10 → O_cache_ren at t+1, O_mac_valid at t+3 with that MAC, no O_arp_req.
- Miss then reply: cache returns 0, and a reply for 192.168.1.20 with MAC 48'hAABB_CCDD_EEFF arrives 50 cycles after O_arp_req → single O_arp_req, O_mac_valid next cycle with that MAC.
- Timeout and failure:
  - Setup: TIMEOUT_CYCLES=20, RETRY_MAX=3, only replies from 192.168.1.99.
  - Required: 3 O_arp_req pulses spaced 21 cycles apart, O_fail after the third expiry, O_mac unchanged.
- Broadcast: I_req_ip=32'hFFFF_FFFF → O_mac_valid at t+1, O_mac=48'hFFFF_FFFF_FFFF, no cache read.
- Boundaries:
  - Matching reply in the timer==0 cycle → success, no extra O_arp_req.
  - A second I_req during ARP_WAIT → ignored, target unchanged.
- Reset mid-ARP_WAIT: drop I_reset_n for 1 cycle → all outputs 0, no pulse; a later reply is ignored; a new request is serviced normally.

Source files
------------

// File: rtl/arp_resolver_if.sv
// Signal bundle between the resolver and its requester, MAC cache and ARP tx/rx stages.
// slave = resolver side, master = environment side.
interface arp_resolver_if;
    logic        I_req;
    logic [31:0] I_req_ip;
    logic        O_busy;
    logic        O_cache_ren;
    logic [31:0] O_cache_rip;
    logic [47:0] I_cache_mac;
    logic        I_cache_done;
    logic        O_arp_req;
    logic [31:0] O_arp_req_ip;
    logic        I_arp_rx_valid;
    logic [31:0] I_arp_rx_ip;
    logic [47:0] I_arp_rx_mac;
    logic        O_mac_valid;
    logic [47:0] O_mac;
    logic        O_fail;

    modport slave (
        input  I_req, I_req_ip, I_cache_mac, I_cache_done,
               I_arp_rx_valid, I_arp_rx_ip, I_arp_rx_mac,
        output O_busy, O_cache_ren, O_cache_rip, O_arp_req, O_arp_req_ip,
               O_mac_valid, O_mac, O_fail
    );

    modport master (
        output I_req, I_req_ip, I_cache_mac, I_cache_done,
               I_arp_rx_valid, I_arp_rx_ip, I_arp_rx_mac,
        input  O_busy, O_cache_ren, O_cache_rip, O_arp_req, O_arp_req_ip,
               O_mac_valid, O_mac, O_fail
    );
endinterface

// File: rtl/arp_resolver.sv
// Next-hop MAC resolver: cache lookup, then ARP request/retry on miss.
// All outputs are flops loaded from the next-state decode.
//
// state         | meaning
// --------------+-------------------------------------------------
// S_IDLE        | waiting for a resolve request
// S_LOOKUP      | cache read strobe cycle
// S_WAIT_LOOKUP | waiting for cache read data
// S_ARP_SEND    | ARP request pulse, timer load, retry count++
// S_ARP_WAIT    | waiting for matching reply or timer expiry
// S_DONE        | success pulse, O_mac updated
// S_FAIL        | failure pulse after the last attempt expired
module arp_resolver #(
    parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic          I_clk,
    input  logic          I_reset_n,
    arp_resolver_if.slave bus
);
    localparam int unsigned        TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [3:0]         RETRY_LIM  = 4'(RETRY_MAX);
    localparam logic [31:0]        BCAST_IP   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_LOOKUP,
        S_ARP_SEND,
        S_ARP_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic [47:0]        mac_q, mac_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         retry_q, retry_d;
    logic               busy_q, ren_q, arp_q, mac_valid_q, fail_q;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        mac_d    = mac_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        case (state_q)
            S_IDLE: begin
                if (bus.I_req) begin
                    target_d = bus.I_req_ip;
                    if (bus.I_req_ip == BCAST_IP) begin
                        mac_d   = 48'hFFFF_FFFF_FFFF;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: state_d = S_WAIT_LOOKUP;
            S_WAIT_LOOKUP: begin
                if (bus.I_cache_done) begin
                    if (bus.I_cache_mac != 48'd0) begin
                        mac_d   = bus.I_cache_mac;
                        state_d = S_DONE;
                    end else begin
                        retry_d = 4'd0;
                        state_d = S_ARP_SEND;
                    end
                end
            end
            S_ARP_SEND: begin
                retry_d = retry_q + 4'd1;
                timer_d = TIMER_LOAD;
                state_d = S_ARP_WAIT;
            end
            S_ARP_WAIT: begin
                // a matching reply takes priority over expiry in the same cycle
                if (bus.I_arp_rx_valid && (bus.I_arp_rx_ip == target_q)) begin
                    mac_d   = bus.I_arp_rx_mac;
                    state_d = S_DONE;
                end else if (timer_q == '0) begin
                    state_d = (retry_q < RETRY_LIM) ? S_ARP_SEND : S_FAIL;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            mac_q       <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            busy_q      <= 1'b0;
            ren_q       <= 1'b0;
            arp_q       <= 1'b0;
            mac_valid_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            mac_q       <= mac_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            busy_q      <= (state_d != S_IDLE);
            ren_q       <= (state_d == S_LOOKUP);
            arp_q       <= (state_d == S_ARP_SEND);
            mac_valid_q <= (state_d == S_DONE);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign bus.O_busy       = busy_q;
    assign bus.O_cache_ren  = ren_q;
    assign bus.O_cache_rip  = target_q;
    assign bus.O_arp_req    = arp_q;
    assign bus.O_arp_req_ip = target_q;
    assign bus.O_mac_valid  = mac_valid_q;
    assign bus.O_mac        = mac_q;
    assign bus.O_fail       = fail_q;
endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver: a short-timeout instance (20 cycles) and a
// long-timeout instance (100 cycles) share one stimulus stream.
module tb_arp_resolver;
    logic        I_clk     = 1'b0;
    logic        I_reset_n = 1'b0;
    logic        req       = 1'b0;
    logic [31:0] req_ip    = '0;
    logic        cache_done = 1'b0;
    logic [47:0] cache_mac  = '0;
    logic        rx_valid  = 1'b0;
    logic [31:0] rx_ip     = '0;
    logic [47:0] rx_mac    = '0;
    logic [31:0] cache_ip  = '0;
    logic [47:0] cache_val = '0;
    logic        pend      = 1'b0;
    logic [47:0] pend_mac  = '0;

    int n_tests = 0;
    int n_fail  = 0;

    arp_resolver_if ifa ();
    arp_resolver_if ifb ();

    assign ifa.I_req = req;            assign ifb.I_req = req;
    assign ifa.I_req_ip = req_ip;      assign ifb.I_req_ip = req_ip;
    assign ifa.I_cache_mac = cache_mac;   assign ifb.I_cache_mac = cache_mac;
    assign ifa.I_cache_done = cache_done; assign ifb.I_cache_done = cache_done;
    assign ifa.I_arp_rx_valid = rx_valid; assign ifb.I_arp_rx_valid = rx_valid;
    assign ifa.I_arp_rx_ip = rx_ip;    assign ifb.I_arp_rx_ip = rx_ip;
    assign ifa.I_arp_rx_mac = rx_mac;  assign ifb.I_arp_rx_mac = rx_mac;

    arp_resolver #(.TIMEOUT_CYCLES(20), .RETRY_MAX(3)) u_dut (
        .I_clk(I_clk), .I_reset_n(I_reset_n), .bus(ifa.slave));
    arp_resolver #(.TIMEOUT_CYCLES(100), .RETRY_MAX(3)) u_dut_long (
        .I_clk(I_clk), .I_reset_n(I_reset_n), .bus(ifb.slave));

    always #5 I_clk = ~I_clk;

    // single-entry cache: data returned one cycle after the read strobe
    always @(negedge I_clk) begin
        cache_done = pend;
        cache_mac  = pend ? pend_mac : 48'd0;
        pend       = ifa.O_cache_ren;
        pend_mac   = (ifa.O_cache_rip == cache_ip) ? cache_val : 48'd0;
    end

    typedef struct packed {
        logic        busy;
        logic        ren;
        logic        arp;
        logic        mv;
        logic        fl;
        logic [47:0] mac;
        logic [31:0] rip;
        logic [31:0] aip;
    } obs_t;

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) begin
            o.busy = ifb.O_busy; o.ren = ifb.O_cache_ren; o.arp = ifb.O_arp_req;
            o.mv = ifb.O_mac_valid; o.fl = ifb.O_fail; o.mac = ifb.O_mac;
            o.rip = ifb.O_cache_rip; o.aip = ifb.O_arp_req_ip;
        end else begin
            o.busy = ifa.O_busy; o.ren = ifa.O_cache_ren; o.arp = ifa.O_arp_req;
            o.mv = ifa.O_mac_valid; o.fl = ifa.O_fail; o.mac = ifa.O_mac;
            o.rip = ifa.O_cache_rip; o.aip = ifa.O_arp_req_ip;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          r_done, r_fail, r_ren_k, r_ren_cnt, r_arp_cnt;
    int          r_arp_k[8];
    logic [47:0] r_mac;
    logic [31:0] r_rip_end;
    logic        r_busy_bad, r_aip_bad;

    // Pulses I_req in the next cycle (t), then samples cycles t+k.
    task automatic run(input bit sel, input logic [31:0] ip, input int max_k,
                       input int rx_at, input logic [31:0] rx_ip_v, input logic [47:0] rx_mac_v,
                       input int req2_at, input logic [31:0] req2_ip);
        obs_t o;
        r_done = -1; r_fail = -1; r_ren_k = -1; r_ren_cnt = 0; r_arp_cnt = 0;
        for (int i = 0; i < 8; i++) r_arp_k[i] = -1;
        r_mac = '0; r_rip_end = '0; r_busy_bad = 1'b0; r_aip_bad = 1'b0;
        @(negedge I_clk);
        req = 1'b1; req_ip = ip;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge I_clk);
            req = 1'b0; rx_valid = 1'b0;
            o = sample(sel);
            if (!o.busy) r_busy_bad = 1'b1;
            if (o.ren) begin
                if (r_ren_k < 0) r_ren_k = k;
                r_ren_cnt++;
            end
            if (o.arp) begin
                if (r_arp_cnt < 8) r_arp_k[r_arp_cnt] = k;
                r_arp_cnt++;
                if (o.aip != o.rip) r_aip_bad = 1'b1;
            end
            r_rip_end = o.rip;
            if (o.mv) begin r_done = k; r_mac = o.mac; break; end
            if (o.fl) begin r_fail = k; r_mac = o.mac; break; end
            if (k == rx_at) begin rx_valid = 1'b1; rx_ip = rx_ip_v; rx_mac = rx_mac_v; end
            if (k == req2_at) begin req = 1'b1; req_ip = req2_ip; end
        end
        req = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ifa.O_busy || ifb.O_busy) && n < 600) begin
            @(negedge I_clk);
            n++;
        end
        chk("idle_reached", 128'(n < 600), 128'd1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] ip;
        logic [31:0] c_ip;
        logic [47:0] c_mac;
        int          exp_ren_k;
        int          exp_done;
        logic [47:0] exp_mac;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        logic [47:0] mac_before;
        int          stray;

        vecs[0] = '{"hit_c0a8010a", 32'hC0A8_010A, 32'hC0A8_010A, 48'h0011_2233_4455, 1, 3, 48'h0011_2233_4455};
        vecs[1] = '{"bcast",        32'hFFFF_FFFF, 32'h0000_0000, 48'h0000_0000_0000, -1, 1, 48'hFFFF_FFFF_FFFF};
        vecs[2] = '{"hit_min_mac",  32'h0A00_0001, 32'h0A00_0001, 48'h0000_0000_0001, 1, 3, 48'h0000_0000_0001};
        vecs[3] = '{"hit_c0a801fe", 32'hC0A8_01FE, 32'hC0A8_01FE, 48'hFFFF_FFFF_FFFE, 1, 3, 48'hFFFF_FFFF_FFFE};
        vecs[4] = '{"bcast_again",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'h1234_5678_9ABC, -1, 1, 48'hFFFF_FFFF_FFFF};

        repeat (3) @(negedge I_clk);
        chk("reset_outputs_a", 128'(sample(1'b0)), 128'd0);
        chk("reset_outputs_b", 128'(sample(1'b1)), 128'd0);
        I_reset_n = 1'b1;

        // table: hits and broadcasts, issued back to back
        for (int v = 0; v < 5; v++) begin
            cache_ip = vecs[v].c_ip; cache_val = vecs[v].c_mac;
            run(1'b0, vecs[v].ip, 10, -1, '0, '0, -1, '0);
            chk({vecs[v].name, "_done_cycle"}, 128'(r_done), 128'(vecs[v].exp_done));
            chk({vecs[v].name, "_mac"}, 128'(r_mac), 128'(vecs[v].exp_mac));
            chk({vecs[v].name, "_ren_cycle"}, 128'(r_ren_k), 128'(vecs[v].exp_ren_k));
            chk({vecs[v].name, "_arp_count"}, 128'(r_arp_cnt), 128'd0);
            chk({vecs[v].name, "_busy_held"}, 128'(r_busy_bad), 128'd0);
        end

        // miss, reply 50 cycles after the ARP request (100-cycle instance)
        wait_idle();
        cache_ip = 32'h0; cache_val = 48'h0;
        run(1'b1, 32'hC0A8_0114, 120, 53, 32'hC0A8_0114, 48'hAABB_CCDD_EEFF, -1, '0);
        chk("miss_reply_ren_cycle", 128'(r_ren_k), 128'd1);
        chk("miss_reply_arp_count", 128'(r_arp_cnt), 128'd1);
        chk("miss_reply_arp_cycle", 128'(r_arp_k[0]), 128'd3);
        chk("miss_reply_done_cycle", 128'(r_done), 128'd54);
        chk("miss_reply_mac", 128'(r_mac), 128'hAABB_CCDD_EEFF);
        chk("miss_reply_arp_ip", 128'(r_aip_bad), 128'd0);

        // reply lands in the timer==0 cycle: success, no second request
        wait_idle();
        run(1'b0, 32'hC0A8_011E, 60, 23, 32'hC0A8_011E, 48'h0102_0304_0506, -1, '0);
        chk("edge_reply_arp_count", 128'(r_arp_cnt), 128'd1);
        chk("edge_reply_done_cycle", 128'(r_done), 128'd24);
        chk("edge_reply_mac", 128'(r_mac), 128'h0102_0304_0506);

        // second request during ARP_WAIT is ignored
        wait_idle();
        run(1'b0, 32'hC0A8_0128, 60, 15, 32'hC0A8_0128, 48'h0A0B_0C0D_0E0F, 10, 32'hC0A8_0132);
        chk("req2_ren_count", 128'(r_ren_cnt), 128'd1);
        chk("req2_target", 128'(r_rip_end), 128'hC0A8_0128);
        chk("req2_done_cycle", 128'(r_done), 128'd16);
        chk("req2_mac", 128'(r_mac), 128'h0A0B_0C0D_0E0F);

        // three timeouts with only foreign replies -> failure
        wait_idle();
        mac_before = ifa.O_mac;
        run(1'b0, 32'hC0A8_0105, 90, 65, 32'hC0A8_0163, 48'h1122_3344_5566, -1, '0);
        chk("fail_arp_count", 128'(r_arp_cnt), 128'd3);
        chk("fail_arp_cycle0", 128'(r_arp_k[0]), 128'd3);
        chk("fail_arp_cycle1", 128'(r_arp_k[1]), 128'd24);
        chk("fail_arp_cycle2", 128'(r_arp_k[2]), 128'd45);
        chk("fail_cycle", 128'(r_fail), 128'd66);
        chk("fail_no_success", 128'(r_done), -128'sd1);
        chk("fail_mac_unchanged", 128'(r_mac), 128'(mac_before));

        // reset in the middle of ARP_WAIT
        wait_idle();
        run(1'b0, 32'hC0A8_0146, 10, -1, '0, '0, -1, '0);
        chk("rst_pre_arp_count", 128'(r_arp_cnt), 128'd1);
        I_reset_n = 1'b0;
        #1;
        chk("rst_async_a", 128'(sample(1'b0)), 128'd0);
        chk("rst_async_b", 128'(sample(1'b1)), 128'd0);
        @(negedge I_clk);
        I_reset_n = 1'b1;
        chk("rst_held_a", 128'(sample(1'b0)), 128'd0);
        @(negedge I_clk);
        rx_valid = 1'b1; rx_ip = 32'hC0A8_0146; rx_mac = 48'h6655_4433_2211;
        stray = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge I_clk);
            rx_valid = 1'b0;
            o = sample(1'b0);
            if (o.busy || o.ren || o.arp || o.mv || o.fl || (o.mac != 48'd0)) stray++;
        end
        chk("rst_late_reply_ignored", 128'(stray), 128'd0);
        cache_ip = 32'hC0A8_0150; cache_val = 48'h0000_5E00_0101;
        run(1'b0, 32'hC0A8_0150, 10, -1, '0, '0, -1, '0);
        chk("rst_after_done_cycle", 128'(r_done), 128'd3);
        chk("rst_after_mac", 128'(r_mac), 128'h0000_5E00_0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
